// File: rtl/wb_decoder_pkg.sv
// Shared types and default address map for the Wishbone decoder.
package wb_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_ERROR   = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK  = 32'hFFFF_C000;
  localparam logic [31:0] LEDS_BASE = 32'h0000_4000;
  localparam logic [31:0] LEDS_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] UART_BASE = 32'h0000_8000;
  localparam logic [31:0] UART_MASK = 32'hFFFF_F000;

  localparam int DEFAULT_TIMEOUT = 16;
  localparam int IDX_W           = 3;

  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] mask);
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// 8-bit cycle counter that flags when a slave has been silent for Limit cycles.
module wb_watchdog #(
  parameter int Limit = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q;

  assign expired_o = (cnt_q == 8'(Limit - 1));

  // Count silent cycles, holding at the expiry value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else if (clear_i) begin
      cnt_q <= 8'd0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/wb_decoder.sv
// Single-master Wishbone address decoder with a per-access watchdog.
// Unmapped accesses and accesses a slave never answers terminate with err.
module wb_decoder
  import wb_decoder_pkg::*;
#(
  parameter int                         NumSlaves     = 3,
  parameter logic [NumSlaves-1:0][31:0] SlaveBase     = {UART_BASE, LEDS_BASE, RAM_BASE},
  parameter logic [NumSlaves-1:0][31:0] SlaveMask     = {UART_MASK, LEDS_MASK, RAM_MASK},
  parameter int                         TimeoutCycles = DEFAULT_TIMEOUT
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic                         m_cyc_i,
  input  logic                         m_stb_i,
  input  logic                         m_we_i,
  input  logic [31:0]                  m_adr_i,
  input  logic [31:0]                  m_dat_i,
  input  logic [3:0]                   m_sel_i,
  output logic [31:0]                  m_dat_o,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  output logic [31:0]                  s_adr_o,
  output logic [31:0]                  s_dat_o,
  output logic [3:0]                   s_sel_o,
  output logic                         s_we_o,
  output logic [NumSlaves-1:0]         s_cyc_o,
  output logic [NumSlaves-1:0]         s_stb_o,
  input  logic [NumSlaves-1:0][31:0]   s_dat_i,
  input  logic [NumSlaves-1:0]         s_ack_i,
  input  logic [NumSlaves-1:0]         s_err_i,
  output logic                         fault_out,
  output logic [31:0]                  fault_addr_out
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, hit_idx_s;
  logic [31:0]      fault_addr_q;
  logic             hit_s, req_s, active_s, resp_s, expired_s, fault_s;
  logic             sel_ack_s, sel_err_s;
  logic [31:0]      sel_dat_s;

  assign req_s    = m_cyc_i & m_stb_i;
  assign active_s = (state_q == ST_ACTIVE);
  assign fault_s  = (state_q == ST_ERROR) || (state_q == ST_TIMEOUT);

  // Address decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = NumSlaves - 1; i >= 0; i--) begin
      if (addr_hit(m_adr_i, SlaveBase[i], SlaveMask[i])) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(i);
      end
    end
  end

  // Strobe only the latched slave while ACTIVE and pick its response.
  always_comb begin
    sel_ack_s = 1'b0;
    sel_err_s = 1'b0;
    sel_dat_s = 32'h0;
    s_cyc_o   = '0;
    s_stb_o   = '0;
    for (int i = 0; i < NumSlaves; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_ack_s  = s_ack_i[i];
        sel_err_s  = s_err_i[i];
        sel_dat_s  = s_dat_i[i];
        s_cyc_o[i] = active_s & m_cyc_i;
        s_stb_o[i] = active_s & m_stb_i;
      end
    end
  end

  assign resp_s = m_cyc_i & (sel_ack_s | sel_err_s);

  // Next state; a slave response beats a simultaneous watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) state_d = hit_s ? ST_ACTIVE : ST_ERROR;
        else       state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (!m_cyc_i || resp_s) state_d = ST_IDLE;
        else if (expired_s)     state_d = ST_TIMEOUT;
        else                    state_d = ST_ACTIVE;
      end
      ST_ERROR:   state_d = ST_IDLE;
      ST_TIMEOUT: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM state, latched slave index and fault address.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      fault_addr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_s) sel_q <= hit_idx_s;
      if (state_d == ST_ERROR || state_d == ST_TIMEOUT) fault_addr_q <= m_adr_i;
    end
  end

  wb_watchdog #(
    .Limit(TimeoutCycles)
  ) u_watchdog (
    .clk_i    (clk_in),
    .rst_ni   (reset_in),
    .clear_i  (!active_s),
    .en_i     (active_s & ~resp_s),
    .expired_o(expired_s)
  );

  assign s_adr_o        = m_adr_i;
  assign s_dat_o        = m_dat_i;
  assign s_sel_o        = m_sel_i;
  assign s_we_o         = m_we_i;
  assign m_ack_o        = active_s & m_cyc_i & sel_ack_s;
  assign m_err_o        = fault_s | (active_s & m_cyc_i & sel_err_s);
  assign m_dat_o        = active_s ? sel_dat_s : 32'h0;
  assign fault_out      = fault_s;
  assign fault_addr_out = fault_addr_q;

endmodule

// File: tb/tb_wb_decoder.sv
// Directed plus randomized bench for wb_decoder against a cycle-count reference model.
module tb_wb_decoder;

  localparam int NS = 3;
  localparam int TO = 16;

  logic                  clk_in = 1'b0;
  logic                  reset_in;
  logic                  m_cyc, m_stb, m_we;
  logic [31:0]           m_adr, m_wdat, m_rdat;
  logic [3:0]            m_sel;
  logic                  m_ack, m_err;
  logic [31:0]           s_adr, s_wdat;
  logic [3:0]            s_sel;
  logic                  s_we;
  logic [NS-1:0]         s_cyc, s_stb, s_ack, s_err;
  logic [NS-1:0][31:0]   s_rdat;
  logic                  fault;
  logic [31:0]           fault_addr;

  int          checks   = 0;
  int          failures = 0;
  int          lat [NS] = '{0, 0, 0};
  bit          errmode [NS] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] rdat [NS] = '{32'h0, 32'h0, 32'h0};
  int          wcnt [NS] = '{0, 0, 0};
  logic [31:0] base [NS] = '{32'h0000_0000, 32'h0000_4000, 32'h0000_8000};
  logic [31:0] mask [NS] = '{32'hFFFF_C000, 32'hFFFF_FFFC, 32'hFFFF_F000};

  always #5 clk_in = ~clk_in;

  wb_decoder #(
    .NumSlaves(NS),
    .TimeoutCycles(TO)
  ) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .m_cyc_i       (m_cyc),
    .m_stb_i       (m_stb),
    .m_we_i        (m_we),
    .m_adr_i       (m_adr),
    .m_dat_i       (m_wdat),
    .m_sel_i       (m_sel),
    .m_dat_o       (m_rdat),
    .m_ack_o       (m_ack),
    .m_err_o       (m_err),
    .s_adr_o       (s_adr),
    .s_dat_o       (s_wdat),
    .s_sel_o       (s_sel),
    .s_we_o        (s_we),
    .s_cyc_o       (s_cyc),
    .s_stb_o       (s_stb),
    .s_dat_i       (s_rdat),
    .s_ack_i       (s_ack),
    .s_err_i       (s_err),
    .fault_out     (fault),
    .fault_addr_out(fault_addr)
  );

  // Slave models: answer after lat[i] wait cycles of stb (lat < 0 means never).
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      s_ack[i]  = s_stb[i] && (lat[i] >= 0) && (wcnt[i] >= lat[i]) && !errmode[i];
      s_err[i]  = s_stb[i] && (lat[i] >= 0) && (wcnt[i] >= lat[i]) && errmode[i];
      s_rdat[i] = rdat[i];
    end
  end

  always @(posedge clk_in) begin
    for (int i = 0; i < NS; i++) begin
      wcnt[i] <= (s_stb[i] && !s_ack[i] && !s_err[i]) ? wcnt[i] + 1 : 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: which slave, how many cycles after the request, and how it ends.
  function automatic void predict(input logic [31:0] addr, output int sl, output int cyc,
                                  output bit ack, output bit err, output bit flt,
                                  output logic [31:0] dat);
    sl = -1; ack = 1'b0; err = 1'b0; flt = 1'b0; dat = 32'h0; cyc = 1;
    for (int i = 0; i < NS; i++) if (sl < 0 && (addr & mask[i]) == base[i]) sl = i;
    if (sl < 0) begin
      err = 1'b1; flt = 1'b1; cyc = 1;
    end else if (lat[sl] >= 0 && lat[sl] <= TO - 1) begin
      cyc = lat[sl] + 1; ack = !errmode[sl]; err = errmode[sl]; dat = rdat[sl];
    end else begin
      cyc = TO + 1; err = 1'b1; flt = 1'b1;
    end
  endfunction

  // Issue a request at the current negedge; extra=1 when issued in the previous termination cycle.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                         input int extra, input string tag);
    int sl, cyc, n, stray, sel_hi, exp_hi;
    bit eack, eerr, eflt, done, g_ack, g_err, g_flt;
    logic [31:0] edat, g_dat, g_sadr, g_swd;
    logic g_swe;
    predict(addr, sl, cyc, eack, eerr, eflt, edat);
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = addr; m_we = we; m_wdat = wd; m_sel = 4'hF;
    n = 0; stray = 0; sel_hi = 0; done = 1'b0;
    g_ack = 1'b0; g_err = 1'b0; g_flt = 1'b0; g_dat = 32'h0; g_sadr = 32'h0; g_swd = 32'h0; g_swe = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk_in);
      n++;
      for (int i = 0; i < NS; i++) begin
        if (s_stb[i]) begin
          if (i == sl) sel_hi++;
          else         stray++;
        end
      end
      if (m_ack || m_err) begin
        done = 1'b1; g_ack = m_ack; g_err = m_err; g_flt = fault; g_dat = m_rdat;
        g_sadr = s_adr; g_swd = s_wdat; g_swe = s_we;
      end
    end
    exp_hi = (eack || (eerr && !eflt)) ? cyc : cyc - 1;
    chk({tag, "_done"},  32'(done),   32'd1);
    chk({tag, "_lat"},   32'(n),      32'(cyc + extra));
    chk({tag, "_ack"},   32'(g_ack),  32'(eack));
    chk({tag, "_err"},   32'(g_err),  32'(eerr));
    chk({tag, "_fault"}, 32'(g_flt),  32'(eflt));
    chk({tag, "_stray"}, 32'(stray),  32'd0);
    chk({tag, "_stbhi"}, 32'(sel_hi), 32'(exp_hi));
    chk({tag, "_badr"},  g_sadr,      addr);
    chk({tag, "_bdat"},  g_swd,       wd);
    chk({tag, "_bwe"},   32'(g_swe),  32'(we));
    if (eack) chk({tag, "_rdata"}, g_dat, edat);
    if (eflt) chk({tag, "_faddr"}, fault_addr, addr);
  endtask

  task automatic idle(input int k);
    m_cyc = 1'b0; m_stb = 1'b0;
    repeat (k) begin
      @(negedge clk_in);
      chk("idle_fault", 32'(fault), 32'd0);
      chk("idle_rdata", m_rdat, 32'd0);
    end
  endtask

  initial begin
    reset_in = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_adr = 32'h0; m_wdat = 32'h0; m_sel = 4'h0;
    #1;
    chk("rst_ack",   32'(m_ack), 32'd0);
    chk("rst_err",   32'(m_err), 32'd0);
    chk("rst_rdata", m_rdat, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_faddr", fault_addr, 32'd0);
    chk("rst_cyc",   32'(s_cyc), 32'd0);
    chk("rst_stb",   32'(s_stb), 32'd0);
    @(negedge clk_in);
    reset_in = 1'b1;
    idle(2);

    lat[1] = 0;
    run_txn(32'h0000_4000, 1'b1, 32'h5, 0, "led_wr");
    idle(1);
    lat[0] = 3; rdat[0] = 32'hDEAD_BEEF;
    run_txn(32'h0000_0010, 1'b0, 32'h0, 0, "ram_rd");
    idle(1);
    run_txn(32'hF000_0000, 1'b0, 32'h0, 0, "unmapped");
    idle(1);
    lat[2] = -1;
    run_txn(32'h0000_8000, 1'b0, 32'h0, 0, "timeout");
    idle(1);
    lat[2] = TO - 1; rdat[2] = 32'h1234_5678;
    run_txn(32'h0000_8000, 1'b0, 32'h0, 0, "expiry_ack");
    idle(1);
    lat[2] = TO;
    run_txn(32'h0000_8FFC, 1'b1, 32'hA5A5_0001, 0, "late_ack");
    idle(1);
    lat[2] = 2; errmode[2] = 1'b1;
    run_txn(32'h0000_8004, 1'b0, 32'h0, 0, "slave_err");
    idle(1);
    errmode[2] = 1'b0; lat[0] = 0; lat[1] = 0;
    run_txn(32'h0000_4000, 1'b1, 32'h1, 0, "b2b_a");
    run_txn(32'h0000_0004, 1'b1, 32'h2, 1, "b2b_b");
    idle(1);

    // Reset while a silent slave is strobed.
    lat[2] = -1;
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0000_8000; m_we = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("prerst_stb", 32'(s_stb), 32'h4);
    reset_in = 1'b0;
    #1;
    chk("midrst_cyc", 32'(s_cyc), 32'd0);
    chk("midrst_stb", 32'(s_stb), 32'd0);
    chk("midrst_ack", 32'(m_ack), 32'd0);
    chk("midrst_err", 32'(m_err), 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk_in);
    reset_in = 1'b1;
    idle(1);
    lat[1] = 0;
    run_txn(32'h0000_4002, 1'b1, 32'h7, 0, "post_rst");

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int ex;
      case ($urandom_range(0, 4))
        0:       a = $urandom() & 32'h0000_3FFF;
        1:       a = 32'h0000_4000 | ($urandom() & 32'h3);
        2:       a = 32'h0000_8000 | ($urandom() & 32'hFFF);
        3:       a = 32'h0000_4004 | ($urandom() & 32'h3FFC);
        default: a = $urandom();
      endcase
      if ($urandom_range(0, 2) == 0) begin
        ex = 1;
      end else begin
        ex = 0;
        idle(int'($urandom_range(1, 2)));
        for (int i = 0; i < NS; i++) begin
          case ($urandom_range(0, 3))
            0:       lat[i] = -1;
            1:       lat[i] = int'($urandom_range(13, 18));
            default: lat[i] = int'($urandom_range(0, 4));
          endcase
          errmode[i] = ($urandom_range(0, 7) == 0);
          rdat[i]    = $urandom();
        end
      end
      run_txn(a, 1'($urandom_range(0, 1)), $urandom(), ex, "rand");
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
